// File: rtl/ldm_stm_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsm_pkg
// Description : Shared types and constants for the LDM/STM block sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package lsm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned LSM_WORD_BYTES = 4;

    // Addressing mode as {P, U}
    localparam logic [1:0] MODE_DA = 2'b00;
    localparam logic [1:0] MODE_IA = 2'b01;
    localparam logic [1:0] MODE_DB = 2'b10;
    localparam logic [1:0] MODE_IB = 2'b11;

endpackage
`default_nettype wire

// File: rtl/ldm_stm_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : ldm_stm_sequencer_if
// Description : Request/beat bus of the LDM/STM sequencer. The abort pair
//               exists only when LSM_SEQ_ABORT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface ldm_stm_sequencer_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              start;
    logic [15:0]       reg_list;
    logic [ADDR_W-1:0] base;
    logic              pre;
    logic              up;
    logic              ready;
    logic              busy;
    logic              valid;
    logic [3:0]        reg_idx;
    logic [ADDR_W-1:0] addr;
    logic              last;
    logic              done;
    logic [ADDR_W-1:0] wb_base;
`ifdef LSM_SEQ_ABORT_EN
    logic              abort;
    logic              aborted;
`endif

    // Requester / load-store unit side
    modport master (
        output start, reg_list, base, pre, up, ready,
`ifdef LSM_SEQ_ABORT_EN
        output abort,
        input  aborted,
`endif
        input  busy, valid, reg_idx, addr, last, done, wb_base
    );

    // Sequencer side
    modport slave (
        input  start, reg_list, base, pre, up, ready,
`ifdef LSM_SEQ_ABORT_EN
        input  abort,
        output aborted,
`endif
        output busy, valid, reg_idx, addr, last, done, wb_base
    );
endinterface
`default_nettype wire

// File: rtl/ldm_stm_sequencer_one_detector.sv
`default_nettype none
// ============================================================================
// Module      : one_detector
// Description : Index of the lowest (order=1) or highest (order=0) set bit.
// Revision    : 1.0 - initial release
// ============================================================================
module one_detector (
    input  wire logic [15:0] vec,
    input  wire logic        order,
    output logic      [3:0]  idx
);
    always_comb begin
        idx = 4'd0;
        if (order) begin
            // Later assignments win, so scanning downward leaves the lowest
            for (int i = 15; i >= 0; i--) begin
                if (vec[i]) idx = 4'(i);
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (vec[i]) idx = 4'(i);
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/ldm_stm_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ldm_stm_sequencer
// Description : Walks an LDM/STM register list, one register/address per beat,
//               then reports the writeback base. Option: LSM_SEQ_ABORT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ldm_stm_sequencer
    import lsm_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned WORD_BYTES = LSM_WORD_BYTES
) (
    input wire logic               clk,
    input wire logic               rst_n,
    ldm_stm_sequencer_if.slave     bus
);
    function automatic logic [4:0] popcount(input logic [15:0] v);
        logic [4:0] s;
        s = 5'd0;
        for (int i = 0; i < 16; i++) s = s + {4'd0, v[i]};
        return s;
    endfunction

    state_t            r_state;
    logic [15:0]       r_list;
    logic [4:0]        r_count;
    logic              r_up;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_wb;
    logic              r_busy;
    logic              r_valid;
    logic              r_last;
    logic              r_done;
`ifdef LSM_SEQ_ABORT_EN
    logic [ADDR_W-1:0] r_base;
    logic              r_aborted;
`endif

    logic [3:0]        w_idx;
    logic [4:0]        w_n;
    logic [ADDR_W-1:0] w_step;
    logic [ADDR_W-1:0] w_span;
    logic [ADDR_W-1:0] w_start_addr;

    one_detector u_one_detector (
        .vec   (r_list),
        .order (r_up),
        .idx   (w_idx)
    );

    assign w_n    = popcount(bus.reg_list);
    assign w_step = ADDR_W'(WORD_BYTES);
    assign w_span = ADDR_W'(w_n) * w_step;

    always_comb begin
        w_start_addr = bus.base;
        case ({bus.pre, bus.up})
            MODE_IB: w_start_addr = bus.base + w_step;
            MODE_DB: w_start_addr = bus.base - w_step;
            default: w_start_addr = bus.base;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_list    <= 16'd0;
            r_count   <= 5'd0;
            r_up      <= 1'b0;
            r_addr    <= '0;
            r_wb      <= '0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_done    <= 1'b0;
`ifdef LSM_SEQ_ABORT_EN
            r_base    <= '0;
            r_aborted <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_busy <= 1'b1;
                        r_list <= bus.reg_list;
                        r_up   <= bus.up;
                        r_wb   <= bus.up ? bus.base + w_span : bus.base - w_span;
`ifdef LSM_SEQ_ABORT_EN
                        r_base <= bus.base;
`endif
                        if (bus.reg_list != 16'd0) begin
                            r_state <= XFER;
                            r_count <= w_n;
                            r_addr  <= w_start_addr;
                            r_valid <= 1'b1;
                            r_last  <= (w_n == 5'd1);
                        end else begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                XFER: begin
`ifdef LSM_SEQ_ABORT_EN
                    if (bus.abort) begin
                        r_state   <= DONE;
                        r_list    <= 16'd0;
                        r_count   <= 5'd0;
                        r_valid   <= 1'b0;
                        r_last    <= 1'b0;
                        r_done    <= 1'b1;
                        r_aborted <= 1'b1;
                        r_wb      <= r_base;
                    end else
`endif
                    if (bus.ready) begin
                        r_list  <= r_list & ~(16'd1 << w_idx);
                        r_count <= r_count - 5'd1;
                        r_addr  <= r_up ? r_addr + w_step : r_addr - w_step;
                        r_last  <= (r_count == 5'd2);
                        if (r_last) begin
                            r_state <= DONE;
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
`ifdef LSM_SEQ_ABORT_EN
                    r_aborted <= 1'b0;
`endif
                end
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.valid   = r_valid;
    assign bus.reg_idx = w_idx;
    assign bus.addr    = r_addr;
    assign bus.last    = r_last;
    assign bus.done    = r_done;
    assign bus.wb_base = r_wb;
`ifdef LSM_SEQ_ABORT_EN
    assign bus.aborted = r_aborted;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ldm_stm_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ldm_stm_sequencer
// Description : Directed self-checking bench for ldm_stm_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ldm_stm_sequencer;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    ldm_stm_sequencer_if #(.ADDR_W(32)) bus ();

    ldm_stm_sequencer #(.ADDR_W(32), .WORD_BYTES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic beat(input string tag, input logic [3:0] idx, input logic [31:0] addr,
                        input logic last);
        check({tag, "_valid"}, 32'(bus.valid), 32'd1);
        check({tag, "_idx"},   32'(bus.reg_idx), 32'(idx));
        check({tag, "_addr"},  bus.addr, addr);
        check({tag, "_last"},  32'(bus.last), 32'(last));
    endtask

    task automatic done_chk(input string tag, input logic [31:0] wb);
        check({tag, "_done"},  32'(bus.done), 32'd1);
        check({tag, "_valid"}, 32'(bus.valid), 32'd0);
        check({tag, "_wb"},    bus.wb_base, wb);
    endtask

    task automatic idle_chk(input string tag);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic req(input logic [15:0] list, input logic [31:0] base,
                       input logic pre, input logic up);
        bus.start    = 1'b1;
        bus.reg_list = list;
        bus.base     = base;
        bus.pre      = pre;
        bus.up       = up;
        tick();
        bus.start    = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.reg_list = 16'd0;
        bus.base     = 32'd0;
        bus.pre      = 1'b0;
        bus.up       = 1'b0;
        bus.ready    = 1'b1;
`ifdef LSM_SEQ_ABORT_EN
        bus.abort    = 1'b0;
`endif
        tick();
        tick();
        check("rst_busy",  32'(bus.busy), 32'd0);
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_done",  32'(bus.done), 32'd0);
        check("rst_addr",  bus.addr, 32'd0);
        check("rst_wb",    bus.wb_base, 32'd0);
        check("rst_idx",   32'(bus.reg_idx), 32'd0);
        check("rst_last",  32'(bus.last), 32'd0);
        rst_n = 1'b1;
        tick();

        // IA: R0,R1,R3 upward from base
        req(16'h000B, 32'h0000_1000, 1'b0, 1'b1);
        check("ia_busy", 32'(bus.busy), 32'd1);
        beat("ia_b1", 4'd0, 32'h0000_1000, 1'b0); tick();
        beat("ia_b2", 4'd1, 32'h0000_1004, 1'b0); tick();
        beat("ia_b3", 4'd3, 32'h0000_1008, 1'b1); tick();
        done_chk("ia_end", 32'h0000_100C);         tick();
        idle_chk("ia_idle");

        // DB: highest register first, highest address first
        req(16'h8011, 32'h0000_2000, 1'b1, 1'b0);
        beat("db_b1", 4'd15, 32'h0000_1FFC, 1'b0); tick();
        beat("db_b2", 4'd4,  32'h0000_1FF8, 1'b0); tick();
        beat("db_b3", 4'd0,  32'h0000_1FF4, 1'b1); tick();
        done_chk("db_end", 32'h0000_1FF4);          tick();
        idle_chk("db_idle");

        // IB with backpressure; a start while busy must be ignored
        bus.ready = 1'b0;
        req(16'h0006, 32'h0000_0100, 1'b1, 1'b1);
        beat("bp_h1", 4'd1, 32'h0000_0104, 1'b0);
        bus.start = 1'b1; bus.reg_list = 16'hFFFF; bus.base = 32'h0;
        tick();
        bus.start = 1'b0;
        beat("bp_h2", 4'd1, 32'h0000_0104, 1'b0); tick();
        beat("bp_h3", 4'd1, 32'h0000_0104, 1'b0); tick();
        beat("bp_h4", 4'd1, 32'h0000_0104, 1'b0);
        bus.ready = 1'b1;
        tick();
        beat("bp_b2", 4'd2, 32'h0000_0108, 1'b1); tick();
        done_chk("bp_end", 32'h0000_0108);         tick();
        idle_chk("bp_idle");

        // Empty list: no beats, done next cycle
        req(16'h0000, 32'h0000_0040, 1'b0, 1'b1);
        check("empty_busy", 32'(bus.busy), 32'd1);
        done_chk("empty_end", 32'h0000_0040);       tick();
        idle_chk("empty_idle");

        // Address wrap-around
        req(16'h0003, 32'hFFFF_FFFC, 1'b0, 1'b1);
        beat("wr_b1", 4'd0, 32'hFFFF_FFFC, 1'b0); tick();
        beat("wr_b2", 4'd1, 32'h0000_0000, 1'b1); tick();
        done_chk("wr_end", 32'h0000_0004);         tick();
        idle_chk("wr_idle");

        // Asynchronous reset after first beat
        req(16'h0003, 32'hFFFF_FFFC, 1'b0, 1'b1);
        tick();
        beat("rs_b2", 4'd1, 32'h0000_0000, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rs_valid", 32'(bus.valid), 32'd0);
        check("rs_busy",  32'(bus.busy), 32'd0);
        check("rs_addr",  bus.addr, 32'd0);
        check("rs_wb",    bus.wb_base, 32'd0);
        check("rs_last",  32'(bus.last), 32'd0);
        check("rs_idx",   32'(bus.reg_idx), 32'd0);
        tick();
        idle_chk("rs_nodone1");
        rst_n = 1'b1;
        tick();
        idle_chk("rs_nodone2");

`ifdef LSM_SEQ_ABORT_EN
        // Abort on the third beat restores the base
        req(16'h00FF, 32'h0000_0500, 1'b0, 1'b1);
        beat("ab_b1", 4'd0, 32'h0000_0500, 1'b0); tick();
        beat("ab_b2", 4'd1, 32'h0000_0504, 1'b0); tick();
        beat("ab_b3", 4'd2, 32'h0000_0508, 1'b0);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        done_chk("ab_end", 32'h0000_0500);
        check("ab_aborted", 32'(bus.aborted), 32'd1);
        tick();
        idle_chk("ab_idle");
        check("ab_nobeat", 32'(bus.valid), 32'd0);
        check("ab_clear",  32'(bus.aborted), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ldm_stm_sequencer.md
Name: ldm_stm_sequencer

Overview:
Multi-cycle sequencer for LDM/STM block transfers. It latches the 16-bit register list, base address and addressing mode. It then emits one register index and word address per beat to the load/store unit until the list is exhausted, and finally reports the writeback base. The next register is picked by an internal one_detector instance: LSB-first for incrementing modes, MSB-first for decrementing modes.

Parameters:
ADDR_W, 32, address/base width in bits.
WORD_BYTES, 4, address step per beat (fixed at 4 for ARMv4; must be a power of 2).

Ports:
i_clk  in  1  clock, rising edge.
i_rst_n  in  1  asynchronous active-low reset.
i_start  in  1  request a new block transfer; sampled only in IDLE.
i_reg_list  in  16  register list, bit n means Rn.
i_base  in  ADDR_W  base register value.
i_pre  in  1  P bit: 1 = before, 0 = after.
i_up  in  1  U bit: 1 = increment, 0 = decrement.
i_ready  in  1  load/store unit accepts the current beat.
o_busy  out  1  not IDLE.
o_valid  out  1  beat valid.
o_reg_idx  out  4  register index of the current beat.
o_addr  out  ADDR_W  word address of the current beat.
o_last  out  1  current beat is the final one.
o_done  out  1  one-cycle pulse: sequence finished.
o_wb_base  out  ADDR_W  writeback base value; valid while o_done=1.

Behaviour:
- Reset (async, i_rst_n=0):
  - state=IDLE.
  - All outputs 0; internal list, address and count registers cleared.
- Reset mid-transfer: abandons the sequence immediately. No o_done pulse.
- FSM states IDLE, XFER, DONE:
  - IDLE + i_start with nonzero list: latch the list. Compute n = popcount(list) and the start address (below). Go to XFER next cycle.
  - IDLE + i_start with list==0: go to DONE with no beats; o_wb_base = i_base.
  - XFER:
    - o_valid=1.
    - o_reg_idx = one_detector(remaining list, order=i_up latched).
    - o_last=1 when exactly one bit remains.
  - XFER beat handshake (o_valid & i_ready):
    - Clear bit o_reg_idx.
    - Step the address by +WORD_BYTES (up) or -WORD_BYTES (down).
    - If o_last, go to DONE.
  - XFER with i_ready=0: hold all beat outputs stable, no change.
  - DONE: o_done=1 for exactly one cycle, o_valid=0; return to IDLE.
- i_start is ignored while o_busy=1.
- The earliest new i_start is accepted in the cycle after o_done.
- Start address:
  - IA: base
  - IB: base+4
  - DA: base
  - DB: base-4
- Beat order:
  - Decrementing modes walk from the highest register at the highest address downward.
  - The register-to-address mapping matches the architectural lowest-register-at-lowest-address rule.
- Writeback: o_wb_base = base + 4n (up) or base - 4n (down). Computed at start, held in a register.
- Address arithmetic is modulo 2^ADDR_W; wrap-around is silent.
- Beat latency: first o_valid 1 cycle after i_start. Throughput 1 beat/cycle while i_ready=1. Total busy = n+1 cycles minimum.

Optional Feature:
Macro LSM_SEQ_ABORT_EN.
- With the macro: adds input i_abort (1 bit) and output o_aborted (1 bit, reset 0).
  - i_abort=1 during XFER, with or without a handshake: discard the remaining list and go to DONE.
  - In that DONE cycle o_aborted=1 alongside o_done, and o_wb_base = i_base latched (base restored).
  - i_abort is ignored outside XFER.
- Without the macro: no i_abort/o_aborted ports; XFER ends only on the last handshake.

Decomposition:
- Shared package lsm_pkg:
  - State enum {IDLE, XFER, DONE}.
  - WORD_BYTES constant.
  - Mode encoding constants for IA/IB/DA/DB from {P,U}.
- Sub-module: one_detector, instantiated once for next-register selection with i_order driven by the latched U bit.
- popcount(16) is an in-module function.

Test Plan:
1. IA: list=0x000B, base=0x1000, P=0 U=1, i_ready=1 → beats (R0,0x1000),(R1,0x1004),(R3,0x1008). o_last on beat 3. o_done next cycle with o_wb_base=0x100C.
2. DB: list=0x8011, base=0x2000, P=1 U=0 → beats (R15,0x1FFC),(R4,0x1FF8),(R0,0x1FF4). o_wb_base=0x1FF4.
3. Backpressure: IB, list=0x0006, base=0x100, i_ready low 3 cycles on beat 1 → (R1,0x104) held stable 4 cycles, then (R2,0x108). o_wb_base=0x108.
4. Empty list: i_start with list=0, base=0x40 → no o_valid. o_done one cycle later, o_wb_base=0x40. Then IDLE.
5. Wrap and reset: IA, base=0xFFFFFFFC, list=0x0003 → addresses 0xFFFFFFFC, 0x00000000. Repeat and pull i_rst_n low after beat 1 → all outputs 0 asynchronously, no o_done.
6. With LSM_SEQ_ABORT_EN: IA, list=0x00FF, base=0x500, i_abort on beat 3 → o_done=1, o_aborted=1, o_wb_base=0x500. No further beats.
